qpsk_symbol_tx: RTL and testbench
=================================

// Module: qpsk_symbol_tx
// PURPOSE
//  QPSK transmit symbol source for the timing-sync chain: accepts 2-bit symbols over a valid/ready
//  handshake and buffers them in a small FIFO. Gray-maps each symbol to I/Q levels and upsamples to
//  SPS samples per symbol, emitting one sample per clk in the same I_out/Q_out format the symbol
//  timing sync top consumes. Drives the receive chain in loopback benches and on hardware.
// PARAMETERS
//  DATA_WIDTH   16     signed width of I_out/Q_out
//  SPS          4      samples per symbol, >=2
//  AMP          23170  mapped magnitude (~0.707 full scale), positive, < 2^(DATA_WIDTH-1)
//  FIFO_DEPTH   8      symbol FIFO entries, power of 2, >=2
//  PRIME_LEVEL  4      FIFO occupancy required before the first symbol is emitted, 1..FIFO_DEPTH
//  ZERO_STUFF   0      0: hold the symbol value for SPS samples; 1: value on phase 0, zero on other phases
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  rst        in   1           asynchronous, active-low reset
//  enable     in   1           start / stop transmission
//  sym_in     in   2           symbol: bit1 -> I sign, bit0 -> Q sign
//  sym_valid  in   1           sym_in valid
//  sym_ready  out  1           FIFO can accept (= !full)
//  I_out      out  DATA_WIDTH  signed I sample
//  Q_out      out  DATA_WIDTH  signed Q sample
//  valid_out  out  1           I_out/Q_out valid, one sample per clk while running
//  sym_strobe out  1           marks the phase-0 sample of each symbol
//  underrun   out  1           1-clk pulse: FIFO empty at a symbol boundary
// BEHAVIOUR
//  Reset (rst=0): I_out=Q_out=0, valid_out=0, sym_strobe=0, underrun=0, FIFO empty, phase=0, state IDLE.
//    sym_ready=1 once reset is released.
//  FIFO: push when sym_valid&&sym_ready. sym_ready is derived from the registered count only, so it is 0
//    whenever the FIFO is full, even if a pop occurs in the same clk. There is no empty bypass.
//    A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
//    Pushes are accepted in every state.
//  Mapping: a bit value of 0 maps to +AMP, 1 maps to -AMP (sym 00 -> (+A,+A), 11 -> (-A,-A)).
//  States:
//    IDLE : outputs held at zero with valid_out=0. enable=1 -> PRIME.
//    PRIME: wait until count>=PRIME_LEVEL -> RUN, phase=0. enable=0 -> IDLE.
//    RUN  : the phase counter 0..SPS-1 increments every clk and wraps.
//      At phase 0: pop the FIFO and register the mapped values.
//      If the FIFO is empty at phase 0: emit (0,0) for that whole symbol, pulse underrun, stay in RUN.
//      enable=0 lets the current symbol finish; after phase SPS-1 the block goes to IDLE and phase=0.
//      The FIFO contents are retained across the stop.
//  Outputs are registered. The first valid sample appears 1 clk after the PRIME->RUN transition.
//    valid_out stays 1 for every clk in RUN, with no gaps.
//    sym_strobe and underrun are aligned with the phase-0 output sample.
//    Non-phase-0 samples follow ZERO_STUFF.
//  Arithmetic: levels are +-AMP sign-extended to DATA_WIDTH. There is no saturation because AMP is bounded.
//  Reset mid-RUN: asynchronous clear to the reset values. Any partially emitted symbol is discarded.
// CONFIGURATION
//  QPSK_TX_PRBS_EN defined:
//    Adds input port prbs_sel (1 bit) and an internal PRBS-9 (x^9+x^5+1, seed 9'h1FF, reset to seed).
//    When prbs_sel=1, symbols come from the PRBS instead of the FIFO:
//      the PRBS advances 2 bits per symbol, and its first generated bit goes to sym bit1;
//      PRIME is skipped (IDLE -> RUN directly) and underrun never fires;
//      sym_ready=0 and the FIFO is frozen.
//    prbs_sel is sampled only at phase 0.
//  QPSK_TX_PRBS_EN undefined: no prbs_sel port, no PRBS logic, FIFO-only source.
// TESTING
//  1. Reset, then push 00,01,10,11 with enable=1 (SPS=4, ZERO_STUFF=0).
//     -> 16 valid samples: (+A,+A)x4, (+A,-A)x4, (-A,+A)x4, (-A,-A)x4; sym_strobe on samples 0,4,8,12.
//  2. Push 3 symbols with PRIME_LEVEL=4 and enable=1. -> valid_out stays 0.
//     A 4th push -> first sample 2 clks after that push.
//  3. Let the FIFO drain in RUN. -> underrun pulses at the next phase 0 and (0,0) is emitted for 4 clks.
//     A push then resumes the symbols at the following boundary.
//  4. Hold sym_valid=1 with enable=0. -> exactly 8 accepts, then sym_ready=0.
//     enable=1 -> sym_ready returns 1 in the clk after the first pop.
//  5. Drop enable at phase 1. -> phases 2,3 are still emitted, then valid_out=0.
//     Assert rst=0 mid-symbol -> all outputs 0 immediately.
//  6. (QPSK_TX_PRBS_EN) prbs_sel=1, enable=1. -> first symbol from seed 9'h1FF,
//     bit sequence matches the PRBS-9 reference model over 511 symbols, and underrun=0.

Source files
------------

// File: rtl/qpsk_symbol_tx_if.sv
// Symbol-in / sample-out bundle for the QPSK transmit symbol source.
// The master side feeds symbols and observes samples; the slave side is the transmitter.
interface qpsk_symbol_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [1:0]                   sym_in;
    logic                         sym_valid;
    logic                         sym_ready;
    logic signed [DATA_WIDTH-1:0] I_out;
    logic signed [DATA_WIDTH-1:0] Q_out;
    logic                         valid_out;
    logic                         sym_strobe;
    logic                         underrun;

    modport master (
        output sym_in, sym_valid,
        input  sym_ready, I_out, Q_out, valid_out, sym_strobe, underrun
    );

    modport slave (
        input  sym_in, sym_valid,
        output sym_ready, I_out, Q_out, valid_out, sym_strobe, underrun
    );
endinterface

// File: rtl/qpsk_symbol_tx.sv
// QPSK symbol source: FIFO-buffered 2-bit symbols, Gray-mapped to +-AMP and upsampled to SPS samples.
// Optional QPSK_TX_PRBS_EN adds prbs_sel and an internal PRBS-9 symbol source.
module qpsk_symbol_tx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SPS         = 4,
    parameter int AMP         = 23170,
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4,
    parameter int ZERO_STUFF  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
`ifdef QPSK_TX_PRBS_EN
    input  logic                 prbs_sel,
`endif
    qpsk_symbol_tx_if.slave      tx
);
    localparam int PW = $clog2(SPS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [DATA_WIDTH-1:0] POS_LEVEL = DATA_WIDTH'(AMP);
    localparam logic signed [DATA_WIDTH-1:0] NEG_LEVEL = -POS_LEVEL;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [PW-1:0]                phase;
    logic [1:0]                   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [CW-1:0]                count;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         push;
    logic                         pop;
    logic                         phase_zero;
    logic                         phase_last;
    logic                         use_prbs;
    logic [1:0]                   next_sym;
    logic                         sym_avail;
    logic signed [DATA_WIDTH-1:0] hold_i;
    logic signed [DATA_WIDTH-1:0] hold_q;

`ifdef QPSK_TX_PRBS_EN
    logic [8:0] prbs;
    logic       prbs_b1;
    logic       prbs_b0;

    assign use_prbs = prbs_sel;
    // Two feedback bits of x^9+x^5+1 per symbol; b0 is the bit generated after b1 is shifted in.
    assign prbs_b1  = prbs[8] ^ prbs[4];
    assign prbs_b0  = prbs[7] ^ prbs[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prbs <= 9'h1FF;
        end else if (state == RUN && phase_zero && use_prbs) begin
            prbs <= {prbs[6:0], prbs_b1, prbs_b0};
        end
    end
`else
    assign use_prbs = 1'b0;
`endif

    assign fifo_full    = (count == CW'(FIFO_DEPTH));
    assign fifo_empty   = (count == '0);
    assign tx.sym_ready = !fifo_full && !use_prbs;
    assign push         = tx.sym_valid && tx.sym_ready;
    assign phase_zero   = (phase == '0);
    assign phase_last   = (phase == PW'(SPS - 1));
    assign pop          = (state == RUN) && phase_zero && !use_prbs && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tx.sym_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = use_prbs ? RUN : PRIME;
            end
            PRIME: begin
                if (!enable)                                    state_next = IDLE;
                else if (use_prbs || count >= CW'(PRIME_LEVEL)) state_next = RUN;
            end
            RUN: begin
                if (phase_last && !enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        next_sym  = fifo_mem[rd_ptr];
        sym_avail = !fifo_empty;
`ifdef QPSK_TX_PRBS_EN
        if (use_prbs) begin
            next_sym  = {prbs_b1, prbs_b0};
            sym_avail = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (state != RUN || phase_last) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Symbol value is latched at phase 0 so the remaining phases can repeat it without re-reading the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx.I_out      <= '0;
            tx.Q_out      <= '0;
            hold_i        <= '0;
            hold_q        <= '0;
            tx.valid_out  <= 1'b0;
            tx.sym_strobe <= 1'b0;
            tx.underrun   <= 1'b0;
        end else if (state != RUN) begin
            tx.I_out      <= '0;
            tx.Q_out      <= '0;
            hold_i        <= '0;
            hold_q        <= '0;
            tx.valid_out  <= 1'b0;
            tx.sym_strobe <= 1'b0;
            tx.underrun   <= 1'b0;
        end else begin
            tx.valid_out  <= 1'b1;
            tx.sym_strobe <= phase_zero;
            if (phase_zero) begin
                tx.underrun <= !sym_avail;
                if (sym_avail) begin
                    hold_i   <= next_sym[1] ? NEG_LEVEL : POS_LEVEL;
                    hold_q   <= next_sym[0] ? NEG_LEVEL : POS_LEVEL;
                    tx.I_out <= next_sym[1] ? NEG_LEVEL : POS_LEVEL;
                    tx.Q_out <= next_sym[0] ? NEG_LEVEL : POS_LEVEL;
                end else begin
                    hold_i   <= '0;
                    hold_q   <= '0;
                    tx.I_out <= '0;
                    tx.Q_out <= '0;
                end
            end else begin
                tx.underrun <= 1'b0;
                tx.I_out    <= (ZERO_STUFF != 0) ? '0 : hold_i;
                tx.Q_out    <= (ZERO_STUFF != 0) ? '0 : hold_q;
            end
        end
    end
endmodule

// File: tb/tb_qpsk_symbol_tx.sv
// Scoreboard bench for qpsk_symbol_tx: expected samples are queued at each accepted push
// and compared when the DUT emits valid samples.
module tb_qpsk_symbol_tx;
    localparam int DW    = 16;
    localparam int SPS   = 4;
    localparam int AMP   = 23170;
    localparam int DEPTH = 8;
    localparam int PRIME = 4;

    typedef struct {
        logic signed [31:0] i;
        logic signed [31:0] q;
        logic               strobe;
        logic               under;
    } sample_t;

    logic    clk;
    logic    rst;
    logic    enable;
`ifdef QPSK_TX_PRBS_EN
    logic    prbs_sel;
`endif
    int      compared;
    int      mismatched;
    sample_t sb[$];
    sample_t mon_exp;

    qpsk_symbol_tx_if #(.DATA_WIDTH(DW)) bus ();

    qpsk_symbol_tx #(
        .DATA_WIDTH (DW),
        .SPS        (SPS),
        .AMP        (AMP),
        .FIFO_DEPTH (DEPTH),
        .PRIME_LEVEL(PRIME),
        .ZERO_STUFF (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
`ifdef QPSK_TX_PRBS_EN
        .prbs_sel(prbs_sel),
`endif
        .tx      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic pushSymbolExp(input logic [1:0] s);
        sample_t e;
        for (int k = 0; k < SPS; k++) begin
            e.i      = s[1] ? -AMP : AMP;
            e.q      = s[0] ? -AMP : AMP;
            e.strobe = (k == 0);
            e.under  = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic pushUnderrunExp();
        sample_t e;
        for (int k = 0; k < SPS; k++) begin
            e.i      = 0;
            e.q      = 0;
            e.strobe = (k == 0);
            e.under  = (k == 0);
            sb.push_back(e);
        end
    endtask

    // Called away from the rising edge; returns at the falling edge after the accept.
    task automatic applyStimulus(input logic [1:0] s);
        logic rdy;
        int   n;
        n = 0;
        bus.sym_in    = s;
        bus.sym_valid = 1'b1;
        do begin
            rdy = bus.sym_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 64);
        if (rdy) pushSymbolExp(s);
        else     checkOutput("push_accept", rdy, 1);
        @(negedge clk);
        bus.sym_valid = 1'b0;
    endtask

    task automatic waitQueue(input int level, input int limit, input string tag);
        int n;
        n = 0;
        #1;
        while (sb.size() > level && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() > level) checkOutput(tag, sb.size(), level);
    endtask

    always @(negedge clk) begin
        if (rst && bus.valid_out) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", bus.valid_out, 0);
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("sample_I", bus.I_out, mon_exp.i);
                checkOutput("sample_Q", bus.Q_out, mon_exp.q);
                checkOutput("sample_strobe", bus.sym_strobe, mon_exp.strobe);
                checkOutput("sample_underrun", bus.underrun, mon_exp.under);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   accepts;
        int   lat;
        int   n;
        logic rdy_before;

        compared      = 0;
        mismatched    = 0;
        rst           = 1'b0;
        enable        = 1'b0;
        bus.sym_in    = 2'b00;
        bus.sym_valid = 1'b0;
`ifdef QPSK_TX_PRBS_EN
        prbs_sel      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset_I", bus.I_out, 0);
        checkOutput("reset_Q", bus.Q_out, 0);
        checkOutput("reset_valid", bus.valid_out, 0);
        checkOutput("reset_strobe", bus.sym_strobe, 0);
        checkOutput("reset_underrun", bus.underrun, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", bus.sym_ready, 1);

        $display("[TB] four symbols, then drain into underrun and resume");
        enable = 1'b1;
        for (int s = 0; s < 4; s++) applyStimulus(s[1:0]);
        waitQueue(0, 100, "t1_drain");
        pushUnderrunExp();
        applyStimulus(2'b11);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        waitQueue(0, 100, "t3_drain");
        repeat (3) @(negedge clk);
        checkOutput("t5_stopped_valid", bus.valid_out, 0);

        $display("[TB] priming threshold and first-sample latency");
        enable = 1'b1;
        applyStimulus(2'b10);
        applyStimulus(2'b01);
        applyStimulus(2'b00);
        repeat (6) @(negedge clk);
        checkOutput("t2_prime_hold", bus.valid_out, 0);
        applyStimulus(2'b11);
        lat = 0;
        while (!bus.valid_out && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("t2_latency", lat, 2);
        waitQueue(3, 100, "t2_last_symbol");
        enable = 1'b0;
        waitQueue(0, 100, "t2_drain");
        repeat (3) @(negedge clk);
        checkOutput("t2_stopped_valid", bus.valid_out, 0);

        $display("[TB] fill FIFO while stopped");
        enable        = 1'b0;
        accepts       = 0;
        bus.sym_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.sym_in = c[1:0];
            rdy_before = bus.sym_ready;
            @(posedge clk);
            if (rdy_before) begin
                accepts++;
                pushSymbolExp(bus.sym_in);
            end
            @(negedge clk);
        end
        bus.sym_valid = 1'b0;
        checkOutput("t4_accepts", accepts, DEPTH);
        checkOutput("t4_ready_full", bus.sym_ready, 0);
        enable     = 1'b1;
        rdy_before = bus.sym_ready;
        n          = 0;
        #1;
        while (!bus.valid_out && n < 20) begin
            rdy_before = bus.sym_ready;
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("t4_started", bus.valid_out, 1);
        checkOutput("t4_ready_before_pop", rdy_before, 0);
        checkOutput("t4_ready_after_pop", bus.sym_ready, 1);
        waitQueue(3, 200, "t4_last_symbol");
        enable = 1'b0;
        waitQueue(0, 100, "t4_drain");
        repeat (3) @(negedge clk);
        checkOutput("t4_stopped_valid", bus.valid_out, 0);

        $display("[TB] reset in the middle of a symbol");
        enable = 1'b1;
        for (int s = 0; s < 4; s++) applyStimulus(2'(3 - s));
        waitQueue(4 * SPS - 2, 100, "t5_mid_symbol");
        rst = 1'b0;
        #1;
        checkOutput("t5_rst_I", bus.I_out, 0);
        checkOutput("t5_rst_Q", bus.Q_out, 0);
        checkOutput("t5_rst_valid", bus.valid_out, 0);
        checkOutput("t5_rst_strobe", bus.sym_strobe, 0);
        checkOutput("t5_rst_underrun", bus.underrun, 0);
        sb.delete();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_ready_after_reset", bus.sym_ready, 1);
        checkOutput("t5_idle_valid", bus.valid_out, 0);

`ifdef QPSK_TX_PRBS_EN
        begin
            logic [8:0] lfsr;
            logic       b1;
            logic       b0;
            $display("[TB] PRBS-9 symbol source");
            lfsr = 9'h1FF;
            for (int s = 0; s < 511; s++) begin
                b1   = lfsr[8] ^ lfsr[4];
                lfsr = {lfsr[7:0], b1};
                b0   = lfsr[8] ^ lfsr[4];
                lfsr = {lfsr[7:0], b0};
                pushSymbolExp({b1, b0});
            end
            prbs_sel = 1'b1;
            #1;
            checkOutput("t6_ready_frozen", bus.sym_ready, 0);
            enable = 1'b1;
            waitQueue(3, 3000, "t6_last_symbol");
            enable = 1'b0;
            waitQueue(0, 100, "t6_drain");
            repeat (3) @(negedge clk);
            checkOutput("t6_stopped_valid", bus.valid_out, 0);
            prbs_sel = 1'b0;
        end
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
